// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants and helpers for the asynchronous FIFO read-side logic.
//   BUF_DEPTH  : entries in the FWFT holding buffer
//   RD_LATENCY : memory read latency in rclk cycles (fixed at 1)
//   idx_wrap_inc() : advance a buffer index, wrapping the last entry back to 0
package fifo_pkg;

  localparam int BUF_DEPTH  = 3;
  localparam int RD_LATENCY = 1;

  // Highest legal buffer index; index value 3 is never produced.
  localparam logic [1:0] IDX_LAST = 2'd2;

  // Holding-buffer depth as a 3-bit quantity, for comparing against occupancy.
  localparam logic [2:0] BUF_DEPTH_W = 3'd3;

  function automatic logic [1:0] idx_wrap_inc(input logic [1:0] idx);
    logic [1:0] nxt;
    if (idx >= IDX_LAST) begin
      nxt = 2'd0;
    end else begin
      nxt = idx + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rfifo_fwft_chk.sv
// rfifo_fwft_chk
// Property checker for rfifo_fwft, observing only its ports.
// Ports:
//   rclk, rrst_n  clock and asynchronous active-low reset of the observed block
//   rempty        FIFO empty flag seen by the block
//   rinc          read increment issued by the block
//   occ           buffer occupancy reported by the block
module rfifo_fwft_chk (
  input logic       rclk,
  input logic       rrst_n,
  input logic       rempty,
  input logic       rinc,
  input logic [1:0] occ
);

  logic infl_r;

  // Reconstruct the in-flight marker: a read issued at one edge is in flight
  // during the following cycle.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      infl_r <= 1'b0;
    end else begin
      infl_r <= rinc;
    end
  end

  a_no_overcommit: assert property (@(posedge rclk) disable iff (!rrst_n)
    (({1'b0, occ} + {2'b00, infl_r}) <= 3'd3));

  a_no_read_when_empty: assert property (@(posedge rclk) disable iff (!rrst_n)
    (rinc |-> !rempty));

endmodule

// File: rtl/rfifo_fwft.sv
// rfifo_fwft
// Read-side first-word-fall-through adapter for the asynchronous FIFO.
// Issues FIFO reads ahead of demand, captures the one-cycle-late memory data
// into a 3-entry holding buffer and presents it as a valid/ready stream.
// Ports:
//   rclk     in   read-domain clock
//   rrst_n   in   asynchronous active-low reset
//   rempty   in   registered FIFO empty flag (1 after reset)
//   rinc     out  pop one FIFO word at this edge
//   rdata    in   memory read data, valid the cycle after rinc
//   m_valid  out  output word available
//   m_data   out  output word (meaningful only with m_valid)
//   m_ready  in   consumer accepts m_data this cycle
//   occ      out  number of words held in the buffer (0..3)
module rfifo_fwft
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       occ
);

  logic [DSIZE-1:0] store_r [BUF_DEPTH];
  logic [1:0]       widx_r;
  logic [1:0]       ridx_r;
  logic [1:0]       count_r;
  logic             inflight_r;

  logic [2:0]       level_s;
  logic             pop_s;
  logic [1:0]       count_nxt_s;

  // Words already held plus the one possibly still coming back from memory;
  // a new read is only issued while this total leaves a free slot.
  always_comb begin
    level_s = {1'b0, count_r} + {2'b00, inflight_r};
  end

  // rinc depends on registered state only, so the consumer's m_ready never
  // reaches the read-pointer logic combinationally.
  always_comb begin
    if (!rempty && (level_s < BUF_DEPTH_W)) begin
      rinc = 1'b1;
    end else begin
      rinc = 1'b0;
    end
  end

  // Output handshake and occupancy derived from the buffer state.
  always_comb begin
    m_valid = (count_r != 2'd0);
    m_data  = store_r[ridx_r];
    occ     = count_r;
    pop_s   = m_valid && m_ready;
  end

  // Occupancy update; never wraps because count + inflight stays <= 3 and a
  // pop only happens with at least one word held.
  always_comb begin
    count_nxt_s = count_r + {1'b0, inflight_r} - {1'b0, pop_s};
  end

  // Control state: indices, occupancy and the read-in-flight marker.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      widx_r     <= 2'd0;
      ridx_r     <= 2'd0;
      count_r    <= 2'd0;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rinc;
      count_r    <= count_nxt_s;
      if (inflight_r) begin
        widx_r <= idx_wrap_inc(widx_r);
      end
      if (pop_s) begin
        ridx_r <= idx_wrap_inc(ridx_r);
      end
    end
  end

  // Holding-buffer storage; unreset because m_valid gates every read of it.
  always_ff @(posedge rclk) begin
    if (inflight_r) begin
      store_r[widx_r] <= rdata;
    end
  end

endmodule

// File: tb/tb_rfifo_fwft.sv
// tb_rfifo_fwft
// Directed and randomised bench for rfifo_fwft. An upstream FIFO emulation
// answers rinc with a one-cycle-late rdata. A behavioural model tracks every
// issued read as a (word, issue edge) record and derives the required rinc,
// m_valid, occ and m_data each cycle.
module tb_rfifo_fwft;

  logic       rclk;
  logic       rrst_n;
  logic       rempty;
  logic       rinc;
  logic [7:0] rdata;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [1:0] occ;

  rfifo_fwft #(.DSIZE(8)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rinc    (rinc),
    .rdata   (rdata),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .occ     (occ)
  );

  rfifo_fwft_chk u_chk (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rempty (rempty),
    .rinc   (rinc),
    .occ    (occ)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic [7:0] w;
    int         stamp;
  } ent_t;

  int         total = 0;
  int         bad   = 0;
  int         ecount = 0;
  int         n_pop = 0;
  int         rd_pos = 0;
  logic       nxt_ready = 1'b0;
  logic [7:0] q[$];
  logic [7:0] wr_q[$];
  logic [7:0] wr_log[$];
  ent_t       pend_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model step at the falling edge: every issued-but-unconsumed word is a
  // pend_q record; it is in the buffer once one edge has passed since issue.
  task automatic model_step();
    int   arrived;
    logic exp_v;
    logic exp_r;
    ent_t e;
    if (!rrst_n) begin
      pend_q.delete();
      rd_pos = wr_log.size();
      chk("rst_rinc", 32'(rinc), 32'd0);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_occ", 32'(occ), 32'd0);
    end else begin
      arrived = 0;
      foreach (pend_q[i]) begin
        if (pend_q[i].stamp < ecount) arrived++;
      end
      exp_v = (arrived > 0);
      exp_r = !rempty && (pend_q.size() < 3);
      chk("m_rinc", 32'(rinc), 32'(exp_r));
      chk("m_valid", 32'(m_valid), 32'(exp_v));
      chk("m_occ", 32'(occ), 32'(arrived));
      if (exp_v) chk("m_data", 32'(m_data), 32'(pend_q[0].w));
      if (exp_v && m_ready) begin
        void'(pend_q.pop_front());
        n_pop++;
      end
      if (exp_r) begin
        if (rd_pos < wr_log.size()) begin
          e.w     = wr_log[rd_pos];
          e.stamp = ecount + 1;
          rd_pos++;
          pend_q.push_back(e);
        end else begin
          total++;
          bad++;
          $display("FAIL model_src: read expected with no word written");
        end
      end
    end
  endtask

  // One clock cycle: upstream reacts after the rising edge, the model checks
  // at the falling edge, and control returns just after it.
  task automatic cyc();
    logic       r;
    logic [7:0] w;
    r = rinc;
    @(posedge rclk);
    ecount++;
    #1;
    if (!rrst_n) begin
      q.delete();
      wr_q.delete();
      rempty  = 1'b1;
      rdata   = 8'($urandom);
      m_ready = nxt_ready;
    end else begin
      if (r && (q.size() > 0)) rdata = q.pop_front();
      else rdata = 8'($urandom);
      while (wr_q.size() > 0) begin
        w = wr_q.pop_front();
        q.push_back(w);
        wr_log.push_back(w);
      end
      rempty  = (q.size() == 0);
      m_ready = nxt_ready;
    end
    @(negedge rclk);
    model_step();
    #1;
  endtask

  logic [7:0] got_w[$];
  logic [7:0] exp3[5];

  initial begin
    int pulses;
    int base;
    int written;
    rrst_n  = 1'b0;
    rempty  = 1'b1;
    m_ready = 1'b0;
    rdata   = 8'h00;

    // Reset, then idle with the FIFO empty.
    repeat (3) cyc();
    chk("reset_rinc", 32'(rinc), 32'd0);
    chk("reset_valid", 32'(m_valid), 32'd0);
    chk("reset_occ", 32'(occ), 32'd0);
    rrst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle_rinc", 32'(rinc), 32'd0);
      chk("idle_valid", 32'(m_valid), 32'd0);
      chk("idle_occ", 32'(occ), 32'd0);
    end

    // Latency and back-to-back throughput: 0x11, 0x22, 0x33.
    wr_q.push_back(8'h11);
    wr_q.push_back(8'h22);
    wr_q.push_back(8'h33);
    nxt_ready = 1'b1;
    cyc();
    chk("lat_c0_rinc", 32'(rinc), 32'd1);
    chk("lat_c0_valid", 32'(m_valid), 32'd0);
    cyc();
    chk("lat_c1_valid", 32'(m_valid), 32'd0);
    chk("lat_c1_occ", 32'(occ), 32'd0);
    cyc();
    chk("lat_c2_valid", 32'(m_valid), 32'd1);
    chk("lat_c2_data", 32'(m_data), 32'h11);
    cyc();
    chk("popin_occ", 32'(occ), 32'd1);
    chk("popin_data", 32'(m_data), 32'h22);
    cyc();
    chk("tp_c4_data", 32'(m_data), 32'h33);
    cyc();
    chk("tp_c5_valid", 32'(m_valid), 32'd0);

    // Stall with five words queued: only three reads, first word held.
    exp3[0] = 8'h41; exp3[1] = 8'h42; exp3[2] = 8'h43; exp3[3] = 8'h44; exp3[4] = 8'h45;
    for (int i = 0; i < 5; i++) wr_q.push_back(exp3[i]);
    nxt_ready = 1'b0;
    cyc();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (rinc) pulses++;
      if (i >= 4) begin
        chk("stall_occ", 32'(occ), 32'd3);
        chk("stall_data", 32'(m_data), 32'h41);
      end
      cyc();
    end
    chk("stall_pulses", 32'(pulses), 32'd3);
    nxt_ready = 1'b1;
    got_w.delete();
    for (int i = 0; i < 16 && got_w.size() < 5; i++) begin
      cyc();
      if (m_valid) got_w.push_back(m_data);
    end
    chk("drain_count", 32'(got_w.size()), 32'd5);
    for (int i = 0; i < got_w.size() && i < 5; i++) chk("drain_word", 32'(got_w[i]), 32'(exp3[i]));
    repeat (3) cyc();

    // Reset with two words held and one in flight.
    nxt_ready = 1'b0;
    wr_q.push_back(8'hC1);
    wr_q.push_back(8'hC2);
    wr_q.push_back(8'hC3);
    wr_q.push_back(8'hC4);
    repeat (4) cyc();
    chk("prerst_occ", 32'(occ), 32'd2);
    rrst_n = 1'b0;
    rempty = 1'b1;
    q.delete();
    #1;
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("midrst_occ", 32'(occ), 32'd0);
    chk("midrst_rinc", 32'(rinc), 32'd0);
    repeat (2) cyc();
    rrst_n = 1'b1;
    wr_q.push_back(8'hB1);
    wr_q.push_back(8'hB2);
    nxt_ready = 1'b1;
    got_w.delete();
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (m_valid) got_w.push_back(m_data);
    end
    chk("postrst_count", 32'(got_w.size()), 32'd2);
    if (got_w.size() >= 2) begin
      chk("postrst_w0", 32'(got_w[0]), 32'hB1);
      chk("postrst_w1", 32'(got_w[1]), 32'hB2);
    end

    // Random upstream writes and random consumer readiness, 10k words.
    base = n_pop;
    written = 0;
    for (int i = 0; i < 60000; i++) begin
      if ((written < 10000) && ($urandom_range(0, 1) == 1)) begin
        wr_q.push_back(8'($urandom));
        written++;
      end
      nxt_ready = ($urandom_range(0, 1) == 1);
      cyc();
      if ((n_pop - base) >= 10000) break;
    end
    chk("rand_words", 32'(n_pop - base), 32'd10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rfifo_fwft.md
# rfifo_fwft

Read-side first-word-fall-through adapter for the asynchronous FIFO, placed directly downstream of the read-pointer/empty logic and the FIFO memory in the rclk domain. It drives the FIFO read-increment `rinc` and captures the registered memory read data `rdata` into a 3-entry holding buffer. It presents that data to the consumer as a valid/ready stream. The adapter hides the one-cycle memory read latency and sustains one word per rclk cycle without any combinational path from `m_ready` to `rinc`.

## Interface
- DSIZE, 8, data word width.
- rclk  in  1  read-domain clock.
- rrst_n  in  1  reset; asynchronous, active-low.
- rempty  in  1  registered FIFO empty flag from the read-pointer logic; 1 after reset.
- rinc  out  1  read-increment to the read-pointer logic; pops one FIFO word per cycle high.
- rdata  in  DSIZE  memory read data. Synchronous read: the word addressed when `rinc` is high at edge N is valid during the cycle after edge N.
- m_valid  out  1  output word available.
- m_data  out  DSIZE  output word; meaningful only while m_valid=1.
- m_ready  in  1  consumer accepts m_data when m_valid=1.
- occ  out  2  buffered word count, 0..3.

## Operation
- State:
  - buf[0..2]: DSIZE-bit storage, not reset.
  - widx, ridx: 2-bit indices; each wraps 2→0 and never holds 3.
  - count: 2-bit occupancy.
  - inflight: 1 bit, registered copy of rinc.
- rinc = !rempty && (count + inflight < 3). This is a function of registered signals only; m_ready must not appear in it.
- Arrival: when inflight=1, write rdata to buf[widx] and advance widx at the edge.
- m_valid = (count != 0); m_data = buf[ridx]; pop = m_valid && m_ready. On pop, ridx advances at the edge.
- count_next = count + inflight − pop (width-safe). Invariant: count + inflight ≤ 3; a violation is a design error (assertion).
- Simultaneous arrival and pop: count unchanged; both indices advance.
- Order: words leave in exactly the order rinc was issued. No drop, no duplication.
- While m_valid=1 and m_ready=0, m_valid and m_data hold stable.
- Buffer full (count=3) or count+inflight=3: rinc=0 even when rempty=0.
- FIFO empty: rinc=0. Words already buffered or in flight still drain normally.
- occ = count.

## Timing
- Reset values: rinc=0 (rempty=1, count=0), m_valid=0, occ=0, widx=ridx=0, inflight=0. m_data is undefined while m_valid=0.
- Reset mid-operation: any in-flight word is discarded and the buffer is emptied immediately. Upstream read pointer resets on the same rrst_n, so no inconsistency arises.
- Latency, rempty falling to m_valid rising:
  - cycle 0: rempty low, rinc=1.
  - cycle 1: inflight=1, rdata valid.
  - cycle 2: m_valid=1.
- Throughput: with m_ready held at 1 and rempty held at 0, steady state is one word per cycle (count 1, inflight 1).
- After m_ready=0 stalls, at most 3 words are held. No word is lost when rempty and m_ready toggle in the same cycle.

## Structure
- Shared package `fifo_pkg`: BUF_DEPTH=3, RD_LATENCY=1, and the index wrap function (2→0).
- The block is a single module; no sub-module is warranted. The 3-entry buffer is register storage inside the module.
- RD_LATENCY is fixed at 1. Other latencies are out of scope for this block.

## Test plan
- Reset, then release with rempty=1 → rinc, m_valid and occ stay 0 for 20 cycles.
- Write 0x11, 0x22, 0x33; hold m_ready=1 and drop rempty → m_valid rises 2 cycles after rempty falls. Output is 0x11, 0x22, 0x33 on consecutive cycles, then m_valid=0.
- m_ready=0 with 5 words in the FIFO → exactly 3 rinc pulses, occ=3, m_data=first word held stable. Raise m_ready → all 5 words emerge in order.
- Random m_ready (50%) and random upstream writes over 10k words → scoreboard matches order, no rinc while rempty=1, count+inflight never exceeds 3.
- rrst_n asserted with occ=2 and inflight=1 → next cycle m_valid=0, occ=0, rinc=0. After release, stale data never appears.
- Pop and arrival in the same cycle at count=1 → occ stays 1 and m_data advances to the next word.
